// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered, back-pressurable RV32I/RV64I immediate generator.
//
// The immediate is decoded combinationally from the incoming instruction.
// It is then captured into a two-entry skid buffer: main drives out_*, and skid
// holds the overflow entry. This gives full throughput under stalls, and in_ready
// depends on registered state only.
//
// Build option: define IMM_ZIMM_EN to enable the CSR zimm format (src 110).
// When the macro is undefined, src 110 is reserved and flagged illegal.
//
// Parameters: XLEN (32 or 64) datapath width, TAG_W sideband tag width.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   flush                      sync; drop buffered entries and the current input
//   in_valid/in_ready          input handshake (in_ready = !FULL)
//   in_instr, in_imm_src       instruction word and format select
//   in_tag                     sideband carried with the entry
//   out_valid/out_ready        output handshake
//   out_imm, out_tag           extended immediate and its tag
//   out_illegal                reserved/disabled format selected
module imm_gen_pipe #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [2:0]       in_imm_src,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);

    typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

    state_e state_q, state_d;

    logic [XLEN-1:0]  imm_new;
    logic             ill_new;

    logic [XLEN-1:0]  main_imm_q, skid_imm_q;
    logic [TAG_W-1:0] main_tag_q, skid_tag_q;
    logic             main_ill_q, skid_ill_q;

    logic accept, drain;
    logic load_main, load_skid, move_skid;

    // Opcode bits never contribute to an immediate.
    logic unused_opcode;
    assign unused_opcode = ^in_instr[6:0];

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return XLEN'({{32{v[31]}}, v});
    endfunction

    function automatic logic [XLEN-1:0] zext32(input logic [31:0] v);
        return XLEN'({32'b0, v});
    endfunction

    // Immediate decode
    always_comb begin
        imm_new = '0;
        ill_new = 1'b0;
        case (in_imm_src)
            3'b000: imm_new = sext32({{20{in_instr[31]}}, in_instr[31:20]});
            3'b001: imm_new = sext32({{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]});
            3'b010: imm_new = sext32({{19{in_instr[31]}}, in_instr[31], in_instr[7],
                                      in_instr[30:25], in_instr[11:8], 1'b0});
            // RV64 LUI/AUIPC sign-extend bit 31 into the upper word.
            3'b011: imm_new = sext32({in_instr[31:12], 12'b0});
            3'b100: imm_new = sext32({{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                                      in_instr[20], in_instr[30:21], 1'b0});
            3'b101: begin
                if (XLEN == 64) imm_new = zext32({26'b0, in_instr[25:20]});
                else            imm_new = zext32({27'b0, in_instr[24:20]});
            end
`ifdef IMM_ZIMM_EN
            3'b110: imm_new = zext32({27'b0, in_instr[19:15]});
`endif
            default: ill_new = 1'b1;
        endcase
    end

    assign accept = in_valid & in_ready;
    assign drain  = out_valid & out_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StEmpty;
        else        state_q <= state_d;
    end

    // Next state and datapath load controls; flush overrides everything.
    always_comb begin
        state_d   = state_q;
        load_main = 1'b0;
        load_skid = 1'b0;
        move_skid = 1'b0;
        if (flush) begin
            state_d = StEmpty;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (accept) begin
                        state_d   = StOne;
                        load_main = 1'b1;
                    end
                end
                StOne: begin
                    if (accept && drain) begin
                        load_main = 1'b1;
                    end else if (accept) begin
                        state_d   = StFull;
                        load_skid = 1'b1;
                    end else if (drain) begin
                        state_d = StEmpty;
                    end
                end
                StFull: begin
                    if (drain) begin
                        state_d   = StOne;
                        move_skid = 1'b1;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    // Outputs decoded from registered state only
    always_comb begin
        out_valid = (state_q != StEmpty);
        in_ready  = (state_q != StFull);
    end

    // Entry storage; stored entries are moved, never recomputed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_imm_q <= '0;
            main_tag_q <= '0;
            main_ill_q <= 1'b0;
            skid_imm_q <= '0;
            skid_tag_q <= '0;
            skid_ill_q <= 1'b0;
        end else begin
            if (load_main) begin
                main_imm_q <= imm_new;
                main_tag_q <= in_tag;
                main_ill_q <= ill_new;
            end else if (move_skid) begin
                main_imm_q <= skid_imm_q;
                main_tag_q <= skid_tag_q;
                main_ill_q <= skid_ill_q;
            end
            if (load_skid) begin
                skid_imm_q <= imm_new;
                skid_tag_q <= in_tag;
                skid_ill_q <= ill_new;
            end
        end
    end

    assign out_imm     = main_imm_q;
    assign out_tag     = main_tag_q;
    assign out_illegal = main_ill_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe at XLEN=64: the driver pushes hand-computed
// expectations on accept; a forked monitor checks every presented output entry.
module tb_imm_gen_pipe;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned TAG_W = 5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [2:0]       in_imm_src;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic [TAG_W-1:0] out_tag;
    logic             out_illegal;

    imm_gen_pipe #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_imm_src (in_imm_src),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_imm    (out_imm),
        .out_tag    (out_tag),
        .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [TAG_W-1:0] tag;
        logic             ill;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Compares the presented entry against the queue head at every negedge.
    // A held entry is rechecked each stall cycle, so stability is covered too.
    task automatic monitor();
        forever begin
            @(negedge clk);
            if (rst_n && !flush && out_valid) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL unexpected_output: got tag %0d imm %h expected no entry",
                             out_tag, out_imm);
                end else begin
                    n_vec++;
                    if (out_imm !== sb[0].imm || out_tag !== sb[0].tag ||
                        out_illegal !== sb[0].ill) begin
                        n_miss++;
                        $display("FAIL out_entry: got tag %0d imm %h ill %b expected tag %0d imm %h ill %b",
                                 out_tag, out_imm, out_illegal, sb[0].tag, sb[0].imm, sb[0].ill);
                    end
                    if (out_ready) void'(sb.pop_front());
                end
            end
        end
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [31:0] instr, input logic [2:0] src,
                        input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] eimm,
                        input logic eill);
        int  tries = 0;
        bit  done  = 0;
        in_valid   = 1'b1;
        in_instr   = instr;
        in_imm_src = src;
        in_tag     = tag;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back('{imm: eimm, tag: tag, ill: eill});
                done = 1;
            end
            @(posedge clk);
            #1;
            tries++;
            if (!done && tries > 50) begin
                n_vec++;
                n_miss++;
                $display("FAIL accept_timeout: got in_ready 0 for 50 cycles expected 1 (tag %0d)",
                         tag);
                done = 1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_empty(input string nm);
        int cyc = 0;
        while (sb.size() != 0 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        n_vec++;
        if (sb.size() != 0) begin
            n_miss++;
            $display("FAIL %s_drain_timeout: got %0d pending entries expected 0", nm, sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        flush      = 1'b0;
        in_valid   = 1'b0;
        in_instr   = '0;
        in_imm_src = '0;
        in_tag     = '0;
        out_ready  = 1'b0;
        fork
            monitor();
        join_none

        #12;
        check("rst_out_valid",   64'(out_valid),   64'd0);
        check("rst_out_imm",     out_imm,          64'd0);
        check("rst_out_tag",     64'(out_tag),     64'd0);
        check("rst_out_illegal", 64'(out_illegal), 64'd0);
        check("rst_in_ready",    64'(in_ready),    64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Format decode, streaming at full rate
        out_ready = 1'b1;
        send(32'hFFF0_0093, 3'b000, 5'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0); // I, -1
        send(32'h7FF0_0093, 3'b000, 5'd2, 64'h0000_0000_0000_07FF, 1'b0); // I, +2047
        send(32'hFE00_0EE3, 3'b010, 5'd3, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0); // B, -4
        send(32'h8000_00B7, 3'b011, 5'd4, 64'hFFFF_FFFF_8000_0000, 1'b0); // U, RV64
        send(32'h00A1_2423, 3'b001, 5'd5, 64'h0000_0000_0000_0008, 1'b0); // S, +8
        send(32'h0080_006F, 3'b100, 5'd6, 64'h0000_0000_0000_0008, 1'b0); // J, +8
        send(32'hFFDF_F06F, 3'b100, 5'd7, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0); // J, -4
        send(32'hFFF0_0013, 3'b101, 5'd8, 64'h0000_0000_0000_003F, 1'b0); // SHAMT, zero-ext
        send(32'hFFFF_FFFF, 3'b111, 5'd9, 64'h0,                   1'b1); // reserved
`ifdef IMM_ZIMM_EN
        send(32'h000F_8000, 3'b110, 5'd10, 64'h0000_0000_0000_001F, 1'b0);
`else
        send(32'h000F_8000, 3'b110, 5'd10, 64'h0, 1'b1);
`endif
        wait_empty("decode");
        @(negedge clk);
        check("idle_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;

        // Backpressure: tags 1, 2 fill the buffer, tag 3 waits
        out_ready = 1'b0;
        send(32'hFFF0_0093, 3'b000, 5'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        send(32'h0080_006F, 3'b100, 5'd2, 64'h0000_0000_0000_0008, 1'b0);
        @(negedge clk);
        check("full_in_ready", 64'(in_ready), 64'd0);
        check("full_out_tag",  64'(out_tag),  64'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(32'hFE00_0EE3, 3'b010, 5'd3, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
        wait_empty("backpressure");

        // Flush while FULL with a same-cycle offer
        out_ready = 1'b0;
        send(32'h7FF0_0093, 3'b000, 5'd10, 64'h0000_0000_0000_07FF, 1'b0);
        send(32'h7FF0_0093, 3'b000, 5'd11, 64'h0000_0000_0000_07FF, 1'b0);
        flush      = 1'b1;
        in_valid   = 1'b1;
        in_tag     = 5'd12;
        sb.delete();
        @(posedge clk);
        #1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        @(negedge clk);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_in_ready",  64'(in_ready),  64'd1);
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // Asynchronous reset while FULL
        out_ready = 1'b0;
        send(32'h0080_006F, 3'b100, 5'd20, 64'h0000_0000_0000_0008, 1'b0);
        send(32'h0080_006F, 3'b100, 5'd21, 64'h0000_0000_0000_0008, 1'b0);
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_in_ready",  64'(in_ready),  64'd1);
        check("arst_out_tag",   64'(out_tag),   64'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("post_rst_in_ready",  64'(in_ready),  64'd1);
        check("post_rst_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        send(32'hFFFF_FFFF, 3'b111, 5'd30, 64'h0, 1'b1);
        wait_empty("post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Registered, back-pressurable immediate generator for the decode stage. It extracts and sign-extends the immediate of any RV32I/RV64I instruction format and carries it across one pipeline boundary with a valid/ready handshake. A two-entry skid buffer gives full throughput under stalls. A synchronous flush supports branch/jump redirect.

## Interface
Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- TAG_W, 5, width of the sideband tag (e.g. rd index or ROB id) carried alongside the immediate.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- flush  in  1  synchronous; discards all buffered entries and the current input.
- in_valid  in  1  input entry offered.
- in_ready  out  1  block can accept; equals NOT skid_valid (registered, no combinational path from out_ready).
- in_instr  in  32  raw instruction word.
- in_imm_src  in  3  format select.
- in_tag  in  TAG_W  sideband, passed through unchanged.
- out_valid  out  1  output entry present.
- out_ready  in  1  consumer accepts.
- out_imm  out  XLEN  extended immediate.
- out_tag  out  TAG_W  tag of the output entry.
- out_illegal  out  1  in_imm_src selected a reserved or disabled format.

## Operation
Format decode (sign bit is instr[31] unless stated):
- 000 I: instr[31:20], sign-extended.
- 001 S: {instr[31:25], instr[11:7]}, sign-extended.
- 010 B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}, sign-extended.
- 011 U: {instr[31:12], 12'b0}. Bits above 31 are filled with instr[31] when XLEN=64 (RV64 LUI/AUIPC).
- 100 J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}, sign-extended.
- 101 SHAMT: zero-extended instr[24:20] (XLEN=32) or instr[25:20] (XLEN=64).
- 110 ZIMM: see Configuration.
- 111 reserved: out_imm = 0, out_illegal = 1.

Buffer state machine:
- Two registers: main (drives out_*) and skid.
- EMPTY: main and skid invalid.
- ONE: main valid, skid invalid.
- FULL: both valid.
- Accept = in_valid & in_ready. Drain = out_valid & out_ready.
- EMPTY, accept → ONE.
- ONE, accept & drain → ONE (main reloaded).
- ONE, accept & !drain → FULL (entry goes to skid).
- ONE, !accept & drain → EMPTY.
- FULL, drain → ONE (skid moves to main). No accept is possible in FULL.
- Order is strictly FIFO. No entry is dropped or duplicated.
- The immediate is computed combinationally from in_* before registering. Stored entries are never recomputed.
- flush: next state EMPTY regardless of in_valid, out_ready, or current state. A same-cycle input is dropped. flush has priority over all other events.

## Timing
- Reset values: out_valid 0, out_imm 0, out_tag 0, out_illegal 0, in_ready 1, state EMPTY.
- Reset mid-operation discards all entries immediately (asynchronous assertion).
- Latency: an entry accepted at edge N appears on out_* after edge N (visible in cycle N+1).
- Throughput: one entry per cycle while out_ready is high.
- While out_valid & !out_ready, out_imm, out_tag, and out_illegal are held stable.
- in_ready falls the cycle after FULL is entered. It rises the cycle after the first drain from FULL.
- The cycle after flush: out_valid 0, in_ready 1.

## Configuration
- IMM_ZIMM_EN defined: src 110 yields zero-extended instr[19:15] (CSR immediate), out_illegal 0.
- IMM_ZIMM_EN undefined: src 110 behaves as reserved (out_imm 0, out_illegal 1). The ZIMM extraction logic is not present.

## Test plan
- I-format: instr 0xFFF00093, src 000, out_ready 1 → next cycle out_valid 1, out_imm 0xFFFFFFFF, out_illegal 0.
- B-format: instr 0xFE000EE3, src 010 → out_imm 0xFFFFFFFC. U-format with XLEN=64: instr 0x800000B7, src 011 → 0xFFFFFFFF80000000.
- Backpressure: out_ready 0, three consecutive in_valid with tags 1, 2, 3 → tags 1 and 2 accepted, in_ready 0 from the third cycle. Raise out_ready → out_tag sequence 1, 2, then 3 accepted, no gaps or loss.
- Flush in FULL with in_valid 1 → next cycle out_valid 0, in_ready 1. The offered entry never appears on the output.
- Reserved src 111 with any instr → out_imm 0, out_illegal 1. src 110 with instr[19:15] = 0x1F → with IMM_ZIMM_EN: out_imm 0x1F, illegal 0; without: out_imm 0, illegal 1.
- Asynchronous reset asserted while FULL → out_valid 0 immediately, without waiting for a clock edge. After release, in_ready 1 and no stale entry emerges.
